// File: rtl/ble_pkg.sv
// rtl/ble_pkg.sv - shared types and constants for the BLE command parser
// Contents:
//   state_t      : parser FSM states
//   ERR_*        : drop reason codes reported on err_code_out
//   CMD_*        : command codes shared with the gameplay controller
package ble_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CHK     = 3'd4
  } state_t;

  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_LENGTH   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [7:0] CMD_SWING = 8'h01;
  localparam logic [7:0] CMD_AIM   = 8'h02;
  localparam logic [7:0] CMD_PAN   = 8'h03;

endpackage

// File: rtl/byte_timeout_timer.sv
// rtl/byte_timeout_timer.sv - saturating inter-byte timeout counter
// Ports:
//   clk_in      : clock
//   rst_in      : synchronous active-high reset
//   en_in       : count one cycle while high
//   clr_in      : return the count to zero (dominates en_in)
//   expired_out : high while the count sits at TIMEOUT_CYCLES
module byte_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 742500
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic en_in,
  input  logic clr_in,
  output logic expired_out
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Holds at LIMIT rather than wrapping so a stalled packet stays expired.
  always_comb begin
    count_d = count_q;
    if (clr_in) begin
      count_d = '0;
    end else if (en_in && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_out = (count_q == LIMIT);

endmodule

// File: rtl/ble_cmd_parser.sv
// rtl/ble_cmd_parser.sv - frames, checks and decodes BLE UART packets into commands
// Packet: HEADER_BYTE, CMD, LEN, LEN payload bytes, CHK (XOR of CMD, LEN, payload).
// Optional: define BLE_PARSER_STATS_EN to add saturating good/error packet counters.
// Ports:
//   clk_in         : pixel clock
//   rst_in         : synchronous active-high reset
//   byte_in        : received byte, valid while byte_valid_in is high
//   byte_valid_in  : single-cycle byte strobe
//   cmd_out        : command code of the last good packet
//   payload_out    : payload of the last good packet, byte i at [8i+7:8i]
//   len_out        : payload length of the last good packet
//   cmd_valid_out  : single-cycle strobe for a good packet
//   err_out        : single-cycle strobe for a dropped packet
//   err_code_out   : drop reason, valid with err_out
//   good_count_out : (stats only) saturating count of good packets
//   err_count_out  : (stats only) saturating count of dropped packets
//   busy_out       : a packet is partially received
module ble_cmd_parser
  import ble_pkg::*;
#(
  parameter int          MAX_PAYLOAD    = 4,
  parameter int          TIMEOUT_CYCLES = 742500,
  parameter logic [7:0]  HEADER_BYTE    = 8'hA5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid_in,
  output logic [7:0]  cmd_out,
  output logic [31:0] payload_out,
  output logic [2:0]  len_out,
  output logic        cmd_valid_out,
  output logic        err_out,
  output logic [1:0]  err_code_out,
`ifdef BLE_PARSER_STATS_EN
  output logic [15:0] good_count_out,
  output logic [15:0] err_count_out,
`endif
  output logic        busy_out
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_PAYLOAD);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  acc_q, acc_d;
  logic [31:0] buf_q, buf_d;

  logic [7:0]  cmd_out_q, cmd_out_d;
  logic [31:0] payload_out_q, payload_out_d;
  logic [2:0]  len_out_q, len_out_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        timer_expired;

  // Timer only runs mid-packet; every accepted byte restarts the window.
  byte_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .en_in       (state_q != IDLE),
    .clr_in      (byte_valid_in || (state_q == IDLE)),
    .expired_out (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    len_d         = len_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    buf_d         = buf_q;
    cmd_out_d     = cmd_out_q;
    payload_out_d = payload_out_q;
    len_out_d     = len_out_q;
    cmd_valid_d   = 1'b0;
    err_d         = 1'b0;
    err_code_d    = err_code_q;

    // A byte on the expiry cycle takes priority over the timeout.
    if (byte_valid_in) begin
      case (state_q)
        IDLE: begin
          if (byte_in == HEADER_BYTE) begin
            state_d = CMD;
          end
        end
        CMD: begin
          cmd_d   = byte_in;
          acc_d   = byte_in;
          state_d = LEN;
        end
        LEN: begin
          acc_d = acc_q ^ byte_in;
          len_d = byte_in[2:0];
          idx_d = 3'd0;
          // Clear so payload bytes at and above the length read as zero.
          buf_d = '0;
          if (byte_in > MAX_LEN_B) begin
            err_d      = 1'b1;
            err_code_d = ERR_LENGTH;
            state_d    = IDLE;
          end else if (byte_in == 8'd0) begin
            state_d = CHK;
          end else begin
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          buf_d[{idx_q[1:0], 3'b000} +: 8] = byte_in;
          acc_d = acc_q ^ byte_in;
          idx_d = idx_q + 3'd1;
          if (idx_q == (len_q - 3'd1)) begin
            state_d = CHK;
          end
        end
        CHK: begin
          if (byte_in == acc_q) begin
            cmd_valid_d   = 1'b1;
            cmd_out_d     = cmd_q;
            payload_out_d = buf_q;
            len_out_d     = len_q;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CHECKSUM;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if ((state_q != IDLE) && timer_expired) begin
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = IDLE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      buf_q         <= '0;
      cmd_out_q     <= '0;
      payload_out_q <= '0;
      len_out_q     <= '0;
      cmd_valid_q   <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      buf_q         <= buf_d;
      cmd_out_q     <= cmd_out_d;
      payload_out_q <= payload_out_d;
      len_out_q     <= len_out_d;
      cmd_valid_q   <= cmd_valid_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign cmd_out       = cmd_out_q;
  assign payload_out   = payload_out_q;
  assign len_out       = len_out_q;
  assign cmd_valid_out = cmd_valid_q;
  assign err_out       = err_q;
  assign err_code_out  = err_code_q;
  assign busy_out      = (state_q != IDLE);

`ifdef BLE_PARSER_STATS_EN
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (cmd_valid_q && (good_cnt_q != 16'hFFFF)) begin
      good_cnt_d = good_cnt_q + 16'd1;
    end
    if (err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign good_count_out = good_cnt_q;
  assign err_count_out  = err_cnt_q;
`endif

endmodule
